gpio_key_input: RTL and testbench

Input-side counterpart of the CPU's GPIO output path to the 7-segment display and LEDs. Samples raw active-low push-buttons and switches and synchronizes them to clk. Debounces each line on a prescaled tick and presents stable levels plus sticky press/release event flags. The CPU core reads the flags over the GPIO bus and clears them with a mask strobe; an interrupt-style summary line is also provided.

---
 rtl/gpio_key_input.sv | 109 ++++++++++
 tb/tb_gpio_key_input.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/gpio_key_input.sv
// gpio_key_input: synchronizes and debounces active-low push-buttons and switches.
// Presents stable levels and sticky press/release flags to the CPU over the GPIO bus.
//
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   ikey      raw key lines, active-low (0 = pressed), asynchronous to clk
//   clr_stb   one-cycle strobe that clears the flags selected by clr_mask
//   clr_mask  per-key clear select, used only while clr_stb=1
//   ostat     debounced level, active-high (1 = pressed)
//   opress    sticky flag, set on a debounced 0->1 transition
//   orelease  sticky flag, set on a debounced 1->0 transition
//   otick     one-cycle debounce tick pulse
//   oirq      OR of all opress and orelease bits
module gpio_key_input #(
  parameter int unsigned NKEYS     = 4,
  parameter int unsigned TICK_DIV  = 50000,
  parameter int unsigned DEB_TICKS = 20,
  parameter int unsigned CW        = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] ikey,
  input  logic             clr_stb,
  input  logic [NKEYS-1:0] clr_mask,
  output logic [NKEYS-1:0] ostat,
  output logic [NKEYS-1:0] opress,
  output logic [NKEYS-1:0] orelease,
  output logic             otick,
  output logic             oirq
);

  localparam int unsigned   PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_TICKS - 1);

  logic [PW-1:0]          pre_q, pre_d;
  logic                   tick_q, tick_d;
  logic [NKEYS-1:0]       sync1_q, sync2_q;
  logic [NKEYS-1:0][CW-1:0] cnt_q, cnt_d;
  logic [NKEYS-1:0]       stat_q, stat_d;
  logic [NKEYS-1:0]       press_q, press_d;
  logic [NKEYS-1:0]       rel_q, rel_d;
  logic [NKEYS-1:0]       samp;
  logic [NKEYS-1:0]       set_press, set_rel;
  logic [NKEYS-1:0]       clr;

  // State registers; synchronizers reset to the idle (released) level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_q   <= '0;
      tick_q  <= 1'b0;
      sync1_q <= '1;
      sync2_q <= '1;
      cnt_q   <= '0;
      stat_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
    end else begin
      pre_q   <= pre_d;
      tick_q  <= tick_d;
      sync1_q <= ikey;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      stat_q  <= stat_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  // Prescaler, per-key debounce and sticky flag next-state
  always_comb begin
    pre_d     = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    tick_d    = (pre_q == PRE_LAST);
    samp      = ~sync2_q;
    cnt_d     = cnt_q;
    stat_d    = stat_q;
    set_press = '0;
    set_rel   = '0;

    if (tick_q) begin
      for (int unsigned i = 0; i < NKEYS; i++) begin
        if (samp[i] == stat_q[i]) begin
          // Matching sample restarts the run, rejecting glitches
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          stat_d[i]    = samp[i];
          cnt_d[i]     = '0;
          set_press[i] = samp[i];
          set_rel[i]   = ~samp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end

    // Clear is applied first so a same-cycle set wins
    clr     = clr_stb ? clr_mask : '0;
    press_d = (press_q & ~clr) | set_press;
    rel_d   = (rel_q & ~clr) | set_rel;
  end

  assign ostat    = stat_q;
  assign opress   = press_q;
  assign orelease = rel_q;
  assign otick    = tick_q;
  assign oirq     = |{press_q, rel_q};

endmodule

// File: tb/tb_gpio_key_input.sv
// tb_gpio_key_input: directed plus randomized checks of gpio_key_input against a
// cycle-level behavioural model (TICK_DIV=4, DEB_TICKS=3).
module tb_gpio_key_input;

  localparam int unsigned NK  = 4;
  localparam int unsigned TD  = 4;
  localparam int unsigned DT  = 3;
  localparam int unsigned CWL = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [NK-1:0] ikey;
  logic          clr_stb;
  logic [NK-1:0] clr_mask;
  logic [NK-1:0] ostat, opress, orelease;
  logic          otick, oirq;

  gpio_key_input #(
    .NKEYS(NK), .TICK_DIV(TD), .DEB_TICKS(DT), .CW(CWL)
  ) dut (
    .clk(clk), .rst(rst), .ikey(ikey), .clr_stb(clr_stb), .clr_mask(clr_mask),
    .ostat(ostat), .opress(opress), .orelease(orelease), .otick(otick), .oirq(oirq)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural model: cycle count since reset, raw key history, and per-key
  // number of consecutive ticks whose sample disagreed with the accepted level.
  logic [NK-1:0] m_stat, m_press, m_rel;
  logic [NK-1:0] h1, h2;
  int unsigned   run [NK];
  int unsigned   cyc;
  logic          m_tick;

  task automatic chk(input string tag, input logic [NK-1:0] obs, input logic [NK-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ostat"}, ostat, m_stat);
    chk({tag, ".opress"}, opress, m_press);
    chk({tag, ".orelease"}, orelease, m_rel);
    chk({tag, ".otick"}, NK'(otick), NK'(m_tick));
    chk({tag, ".oirq"}, NK'(oirq), NK'(|{m_press, m_rel}));
  endtask

  task automatic model_reset();
    m_stat  = '0;
    m_press = '0;
    m_rel   = '0;
    h1      = '1;
    h2      = '1;
    cyc     = 0;
    m_tick  = 1'b0;
    for (int k = 0; k < int'(NK); k++) run[k] = 0;
  endtask

  // Would key k be accepted on the coming clock edge?
  function automatic logic will_accept(input int k);
    return m_tick && ((~h2[k]) != m_stat[k]) && (run[k] == DT - 1);
  endfunction

  // One clock: advance the model with the inputs seen at the edge, then check
  task automatic step(input string tag);
    logic [NK-1:0] sp, sr;
    logic          smp;
    @(posedge clk);
    sp = '0;
    sr = '0;
    if (m_tick) begin
      for (int k = 0; k < int'(NK); k++) begin
        smp = ~h2[k];
        if (smp == m_stat[k]) begin
          run[k] = 0;
        end else begin
          run[k]++;
          if (run[k] == DT) begin
            m_stat[k] = smp;
            run[k]    = 0;
            if (smp) sp[k] = 1'b1;
            else     sr[k] = 1'b1;
          end
        end
      end
    end
    if (clr_stb) begin
      m_press = m_press & ~clr_mask;
      m_rel   = m_rel & ~clr_mask;
    end
    m_press = m_press | sp;
    m_rel   = m_rel | sr;
    h2      = h1;
    h1      = ikey;
    cyc++;
    m_tick  = (cyc % TD) == 0;
    #1;
    check_all(tag);
    clr_stb = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b0;
    #1;
    model_reset();
    check_all("reset_async");
    repeat (cycles) begin
      @(posedge clk);
      #1;
      check_all("reset_hold");
    end
    rst = 1'b1;
  endtask

  initial begin
    bit fired;
    rst      = 1'b1;
    ikey     = '1;
    clr_stb  = 1'b0;
    clr_mask = '0;
    model_reset();
    #2;
    do_reset(3);

    // Idle keys: no events, tick every TD cycles
    repeat (100) step("idle");
    chk("idle_oirq", NK'(oirq), '0);

    // Press key 0 and hold
    ikey[0] = 1'b0;
    repeat (20) step("press0");
    chk("press0_stat", ostat, 4'b0001);
    chk("press0_flag", opress, 4'b0001);

    // Glitch on key 1 spanning two ticks is rejected
    ikey[1] = 1'b0;
    repeat (6) step("glitch1");
    ikey[1] = 1'b1;
    repeat (12) step("glitch1_after");
    chk("glitch1_stat", NK'(ostat[1]), '0);
    chk("glitch1_flag", NK'(opress[1]), '0);

    // Release key 0, then clear its flags
    ikey[0] = 1'b1;
    repeat (20) step("release0");
    chk("release0_flag", orelease, 4'b0001);
    clr_stb  = 1'b1;
    clr_mask = 4'b0001;
    step("clear0");
    chk("clear0_irq", NK'(oirq), '0);
    step("clear0_after");

    // Clear strobe on the exact acceptance edge of key 2: set wins
    ikey[2] = 1'b0;
    fired   = 1'b0;
    for (int i = 0; i < 40 && !fired; i++) begin
      if (will_accept(2)) begin
        clr_stb  = 1'b1;
        clr_mask = 4'b0100;
        fired    = 1'b1;
      end
      step("setwins");
    end
    chk("setwins_reached", NK'(fired), NK'(1'b1));
    chk("setwins_press2", NK'(opress[2]), NK'(1'b1));
    ikey[2] = 1'b1;
    repeat (20) step("release2");

    // Reset mid-debounce on key 3, key held through and after reset
    ikey[3] = 1'b0;
    repeat (9) step("deb3");
    do_reset(1);
    repeat (8) step("deb3_post");
    chk("deb3_early", NK'(ostat[3]), '0);
    repeat (12) step("deb3_post2");
    chk("deb3_accepted", NK'(ostat[3]), NK'(1'b1));
    ikey[3] = 1'b1;
    repeat (20) step("release3");

    // Randomized key activity with random hold lengths and clear strobes
    for (int blk = 0; blk < 150; blk++) begin
      ikey = ikey ^ NK'($urandom_range(0, (1 << NK) - 1) & $urandom_range(0, (1 << NK) - 1));
      for (int c = 0; c < int'($urandom_range(1, 18)); c++) begin
        if ($urandom_range(0, 7) == 0) begin
          clr_stb  = 1'b1;
          clr_mask = NK'($urandom_range(0, (1 << NK) - 1));
        end
        step("random");
      end
      if (blk == 75) do_reset(2);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
